// File: rtl/aes_key_pkg.sv
// AES-128 round key types, fetch FSM states and the round-to-address map.
// Shared by the key expansion writer and the round key fetch reader.
package aes_key_pkg;

    localparam int NUM_ROUNDS_AES128 = 10;

    typedef logic [127:0] round_key_t;
    typedef logic [3:0]   round_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } fetch_state_t;

    function automatic logic [15:0] round_addr(
        input logic [15:0] base,
        input logic [15:0] stride,
        input round_idx_t  r
    );
        return base + ({12'd0, r} * stride);
    endfunction

endpackage

// File: rtl/round_key_buffer.sv
// Two-entry FIFO of {round tag, round key}; head entry is always presented.
module round_key_buffer
    import aes_key_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [127:0] push_key,
    input  logic [3:0]   push_tag,
    output logic         full,
    output logic         empty,
    output logic [127:0] head_key,
    output logic [3:0]   head_tag
);

    round_key_t key_mem [2];
    round_idx_t tag_mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_mem[0] <= '0;
            key_mem[1] <= '0;
            tag_mem[0] <= '0;
            tag_mem[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                key_mem[wr_ptr] <= push_key;
                tag_mem[wr_ptr] <= push_tag;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_key = key_mem[rd_ptr];
    assign head_tag = tag_mem[rd_ptr];

endmodule

// File: rtl/round_key_fetch.sv
// Streams expanded AES-128 round keys from SRAM to the cipher core,
// ascending for encryption and descending for decryption.
module round_key_fetch
    import aes_key_pkg::*;
#(
    parameter logic [15:0] KEY_BASE_ADDR = 16'h0000,
    parameter logic [15:0] ADDR_STRIDE   = 16'd1,
    parameter int          NUM_ROUNDS    = NUM_ROUNDS_AES128,
    parameter int          READ_LATENCY  = 0
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         decrypt,
    input  logic         abort,
    input  logic         keyAccept,
    output logic         keyReady,
    output logic [127:0] roundKey,
    output logic [3:0]   roundNum,
    output logic         busy,
    output logic         fetchDone,
    output logic         sramRead,
    output logic [15:0]  sramAddr,
    input  logic [127:0] sramReadValue
);

    localparam round_idx_t LAST_RND  = round_idx_t'(NUM_ROUNDS);
    localparam logic [7:0] LAST_WAIT =
        (READ_LATENCY > 0) ? 8'(READ_LATENCY - 1) : 8'd0;
    localparam bit         COMB_SRAM = (READ_LATENCY == 0);

    fetch_state_t state;
    fetch_state_t next;
    logic         dir;
    round_idx_t   idx;
    round_idx_t   pend;
    logic [7:0]   wait_cnt;
    logic         all_issued;
    logic         done_q;
    logic         full;
    logic         empty;
    logic         issue;
    logic         last_idx;
    logic         push;
    logic         pop;
    logic         done_evt;
    round_idx_t   push_tag;

    // Only one read is ever outstanding, so buffer room alone gates a read.
    assign issue    = (state == ST_ISSUE) && !full;
    assign last_idx = dir ? (idx == '0) : (idx == LAST_RND);
    assign pop      = keyAccept && !empty;
    assign push     = !abort && (COMB_SRAM ? issue :
                      ((state == ST_WAIT) && (wait_cnt == LAST_WAIT)));
    assign push_tag = COMB_SRAM ? idx : pend;
    assign done_evt = (state == ST_DRAIN) && !abort && pop && !full;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        if (abort) begin
            next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) next = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (issue) begin
                        if (!COMB_SRAM) next = ST_WAIT;
                        else if (last_idx) next = ST_DRAIN;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == LAST_WAIT)
                        next = all_issued ? ST_DRAIN : ST_ISSUE;
                end
                ST_DRAIN: begin
                    if (done_evt) next = ST_IDLE;
                end
                default: next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        sramRead = issue;
        sramAddr = '0;
        if (issue) begin
            sramAddr = round_addr(KEY_BASE_ADDR, ADDR_STRIDE, idx);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dir        <= 1'b0;
            idx        <= '0;
            pend       <= '0;
            wait_cnt   <= '0;
            all_issued <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= done_evt;
            if ((state == ST_IDLE) && start && !abort) begin
                dir        <= decrypt;
                idx        <= decrypt ? LAST_RND : '0;
                all_issued <= 1'b0;
            end
            if (issue) begin
                pend     <= idx;
                wait_cnt <= '0;
                if (last_idx) all_issued <= 1'b1;
                else idx <= dir ? idx - 4'd1 : idx + 4'd1;
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign fetchDone = done_q;

    round_key_buffer u_buf (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (push),
        .pop      (pop),
        .flush    (abort),
        .push_key (sramReadValue),
        .push_tag (push_tag),
        .full     (full),
        .empty    (empty),
        .head_key (roundKey),
        .head_tag (roundNum)
    );

    assign keyReady = !empty;

endmodule
